axi_burst_addr_seq: RTL and testbench
=====================================

AXI_BURST_ADDR_SEQ -- requirements
Module: axi_burst_addr_seq

Interface
REQ-001 Parameter DATA_WIDTH, default 32, SHALL set the data bus width in bits; the strobe width SHALL be DATA_WIDTH/8.
REQ-002 Parameter ADDR_WIDTH, default 16, SHALL set the byte address width in bits.
REQ-003 ACLK  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004 ARESET  input  1  SHALL be the asynchronous, active-high reset.
REQ-005 cmd_valid  input  1  SHALL mark a burst command as present.
REQ-006 cmd_ready  output  1  SHALL indicate that a command can be accepted.
REQ-007 cmd_addr  input  ADDR_WIDTH  SHALL be the burst start address.
REQ-008 cmd_len  input  8  SHALL be the AXI LEN field; beats = cmd_len+1.
REQ-009 cmd_size  input  3  SHALL be the AXI SIZE field; bytes per beat = 1<<cmd_size.
REQ-010 cmd_burst  input  2  SHALL be the burst type: 00 FIXED, 01 INCR, 10 WRAP, 11 reserved.
REQ-011 cmd_err  output  1  SHALL pulse for one cycle when an illegal command is accepted.
REQ-012 beat_valid  output  1  SHALL mark a valid per-beat address/strobe.
REQ-013 beat_ready  input  1  SHALL be the downstream (SRAM port) acceptance of the current beat.
REQ-014 beat_addr  output  ADDR_WIDTH  SHALL be the current beat byte address.
REQ-015 beat_strb  output  DATA_WIDTH/8  SHALL be the active byte lanes of the current beat.
REQ-016 beat_num  output  8  SHALL be the zero-based index of the current beat.
REQ-017 beat_last  output  1  SHALL be high on the final beat of a burst.

Function
REQ-018 The block SHALL have two states: IDLE (cmd_ready=1, beat_valid=0) and BURST (cmd_ready=0, beat_valid=1).
REQ-019 IDLE->BURST SHALL occur on cmd_valid&&cmd_ready with a legal command; the first beat SHALL be valid in the cycle after acceptance.
REQ-020 A beat SHALL transfer on beat_valid&&beat_ready; with beat_ready held at 1, one beat SHALL be issued per cycle.
REQ-021 beat_addr, beat_strb, beat_num and beat_last SHALL hold stable while beat_valid=1 and beat_ready=0.
REQ-022 BURST->IDLE SHALL occur on transfer of the beat with beat_last=1; no new command SHALL be accepted in that same cycle.
REQ-023 Beat 0 address SHALL equal cmd_addr, unaligned if necessary.
REQ-024 FIXED: every beat address SHALL equal cmd_addr.
REQ-025 INCR: beat n>0 address SHALL be aligned_addr + n*(1<<size), where aligned_addr = (cmd_addr>>size)<<size, truncated to ADDR_WIDTH.
REQ-026 WRAP: with total = (1<<size)*(len+1), lower = (cmd_addr/total)*total and upper = lower+total, a computed address equal to upper SHALL be replaced by lower.
REQ-027 Strobe: with bus_bytes = DATA_WIDTH/8, lo_lane = addr mod bus_bytes and hi_lane = ((addr>>size)<<size) + (1<<size) - 1 - (addr/bus_bytes)*bus_bytes, beat_strb bits lo_lane..hi_lane SHALL be 1 and all other bits 0.
REQ-028 The following commands SHALL be illegal: cmd_burst=11; (1<<cmd_size) > DATA_WIDTH/8; WRAP with cmd_len not in {1,3,7,15}; WRAP with cmd_addr not size-aligned.
REQ-029 An illegal command SHALL be accepted (cmd_ready handshake completes), SHALL assert cmd_err in the next cycle only, SHALL generate no beats, and the block SHALL remain in IDLE.
REQ-030 A 256-beat INCR burst (cmd_len=255) SHALL be supported; beat_num SHALL reach 255 with beat_last=1.

Reset
REQ-031 While ARESET=1: state=IDLE, cmd_ready=0, cmd_err=0, beat_valid=0, beat_last=0, and beat_addr, beat_strb and beat_num all 0.
REQ-032 cmd_ready SHALL rise in the first ACLK cycle after ARESET deasserts.
REQ-033 ARESET asserted mid-burst SHALL abort the burst immediately, with no further beats and no cmd_err.

Configuration
REQ-034 Macro AXI_SEQ_4KB_CHECK_EN defined: an INCR command whose first and last byte fall in different 4KB pages (cmd_addr[ADDR_WIDTH-1:12] differs) SHALL be illegal per REQ-029.
REQ-035 Macro AXI_SEQ_4KB_CHECK_EN undefined: no 4KB check SHALL exist, and such bursts SHALL proceed per REQ-025.

Verification
REQ-036 INCR addr=0x0002, len=3, size=2 -> addrs 0x0002, 0x0004, 0x0008, 0x000C; strb 1100, 1111, 1111, 1111; beat_last on beat 3.
REQ-037 WRAP addr=0x0038, len=3, size=2 -> addrs 0x0038, 0x003C, 0x0030, 0x0034; all strb 1111.
REQ-038 FIXED addr=0x0011, len=2, size=0 -> three beats at 0x0011 with strb 0010; beat_ready toggled 1,0,1,0,1 -> outputs held stable while beat_ready=0.
REQ-039 cmd_burst=11, or size=3 at DATA_WIDTH=32 -> one-cycle cmd_err, no beat_valid; next legal command is accepted normally.
REQ-040 INCR addr=0x0FF0, len=7, size=2 -> with AXI_SEQ_4KB_CHECK_EN: cmd_err, no beats; without: 8 beats ending at 0x100C.
REQ-041 ARESET pulsed at beat 5 of a len=15 INCR burst -> beat_valid=0 immediately, cmd_ready=1 in the first cycle after release.

Source files
------------

// File: rtl/axi_burst_addr_seq.sv
// AXI burst address sequencer: turns one FIXED/INCR/WRAP command into per-beat address/strobe.
// Optional macro AXI_SEQ_4KB_CHECK_EN rejects INCR bursts that cross a 4KB page.
module axi_burst_addr_seq #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 16
) (
    input  logic                    ACLK,
    input  logic                    ARESET,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [7:0]              cmd_len,
    input  logic [2:0]              cmd_size,
    input  logic [1:0]              cmd_burst,
    output logic                    cmd_err,
    output logic                    beat_valid,
    input  logic                    beat_ready,
    output logic [ADDR_WIDTH-1:0]   beat_addr,
    output logic [DATA_WIDTH/8-1:0] beat_strb,
    output logic [7:0]              beat_num,
    output logic                    beat_last
);

    localparam int unsigned STRB_W = DATA_WIDTH / 8;
    localparam int unsigned LANE_W = (STRB_W > 1) ? $clog2(STRB_W) : 1;

    localparam logic [1:0] BurstFixed = 2'b00;
    localparam logic [1:0] BurstIncr  = 2'b01;
    localparam logic [1:0] BurstWrap  = 2'b10;

    typedef enum logic [0:0] {StIdle, StBurst} state_e;

    state_e                  state_q, state_d;
    logic                    cmd_ready_q, cmd_ready_d;
    logic                    cmd_err_q, cmd_err_d;
    logic [ADDR_WIDTH-1:0]   beat_addr_q, beat_addr_d;
    logic [STRB_W-1:0]       beat_strb_q, beat_strb_d;
    logic [7:0]              beat_num_q, beat_num_d;
    logic                    beat_last_q, beat_last_d;
    logic [7:0]              len_q, len_d;
    logic [2:0]              size_q, size_d;
    logic [1:0]              burst_q, burst_d;
    logic [ADDR_WIDTH-1:0]   wrap_lo_q, wrap_lo_d;
    logic [ADDR_WIDTH-1:0]   wrap_hi_q, wrap_hi_d;

    logic [ADDR_WIDTH-1:0]   bytes_a, beats_a, total_a, aligned_a;
    logic [ADDR_WIDTH-1:0]   cur_bytes, incr_a, next_a;
    logic                    size_bad, wrap_len_ok, cmd_illegal;
`ifdef AXI_SEQ_4KB_CHECK_EN
    logic [ADDR_WIDTH-1:0]   last_byte_a;
`endif

    // Lanes from the byte offset up to the end of the size-aligned beat window.
    function automatic logic [STRB_W-1:0] calc_strb(input logic [ADDR_WIDTH-1:0] addr,
                                                    input logic [2:0] size);
        int unsigned nb, lo, hi;
        logic [STRB_W-1:0] strb;
        nb = 32'd1 << size;
        lo = 32'(addr[LANE_W-1:0]) & (STRB_W - 1);
        hi = (lo & ~(nb - 1)) + nb - 1;
        strb = '0;
        for (int unsigned i = 0; i < STRB_W; i++) begin
            strb[i] = (i >= lo) && (i <= hi);
        end
        return strb;
    endfunction

    always_comb begin
        bytes_a     = ADDR_WIDTH'(1) << cmd_size;
        beats_a     = ADDR_WIDTH'(cmd_len) + ADDR_WIDTH'(1);
        total_a     = bytes_a * beats_a;
        aligned_a   = cmd_addr & ~(bytes_a - ADDR_WIDTH'(1));
        size_bad    = (32'd1 << cmd_size) > STRB_W;
        wrap_len_ok = (cmd_len == 8'd1) || (cmd_len == 8'd3) || (cmd_len == 8'd7) ||
                      (cmd_len == 8'd15);
        cmd_illegal = (cmd_burst == 2'b11) || size_bad ||
                      ((cmd_burst == BurstWrap) &&
                       (!wrap_len_ok || ((cmd_addr & (bytes_a - ADDR_WIDTH'(1))) != '0)));
`ifdef AXI_SEQ_4KB_CHECK_EN
        last_byte_a = aligned_a + total_a - ADDR_WIDTH'(1);
        if ((cmd_burst == BurstIncr) &&
            (last_byte_a[ADDR_WIDTH-1:12] != cmd_addr[ADDR_WIDTH-1:12])) begin
            cmd_illegal = 1'b1;
        end
`endif
    end

    always_comb begin
        cur_bytes = ADDR_WIDTH'(1) << size_q;
        incr_a    = (beat_addr_q & ~(cur_bytes - ADDR_WIDTH'(1))) + cur_bytes;
        case (burst_q)
            BurstFixed: next_a = beat_addr_q;
            BurstWrap:  next_a = (incr_a == wrap_hi_q) ? wrap_lo_q : incr_a;
            default:    next_a = incr_a;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        cmd_ready_d = cmd_ready_q;
        cmd_err_d   = 1'b0;
        beat_addr_d = beat_addr_q;
        beat_strb_d = beat_strb_q;
        beat_num_d  = beat_num_q;
        beat_last_d = beat_last_q;
        len_d       = len_q;
        size_d      = size_q;
        burst_d     = burst_q;
        wrap_lo_d   = wrap_lo_q;
        wrap_hi_d   = wrap_hi_q;
        case (state_q)
            StIdle: begin
                cmd_ready_d = 1'b1;
                if (cmd_valid && cmd_ready_q) begin
                    if (cmd_illegal) begin
                        cmd_err_d = 1'b1;
                    end else begin
                        state_d     = StBurst;
                        cmd_ready_d = 1'b0;
                        beat_addr_d = cmd_addr;
                        beat_strb_d = calc_strb(cmd_addr, cmd_size);
                        beat_num_d  = 8'd0;
                        beat_last_d = (cmd_len == 8'd0);
                        len_d       = cmd_len;
                        size_d      = cmd_size;
                        burst_d     = cmd_burst;
                        wrap_lo_d   = cmd_addr & ~(total_a - ADDR_WIDTH'(1));
                        wrap_hi_d   = (cmd_addr & ~(total_a - ADDR_WIDTH'(1))) + total_a;
                    end
                end
            end
            StBurst: begin
                if (beat_ready) begin
                    if (beat_last_q) begin
                        // cmd_ready returns one cycle later, so no same-cycle accept
                        state_d     = StIdle;
                        beat_last_d = 1'b0;
                    end else begin
                        beat_addr_d = next_a;
                        beat_strb_d = calc_strb(next_a, size_q);
                        beat_num_d  = beat_num_q + 8'd1;
                        beat_last_d = ((beat_num_q + 8'd1) == len_q);
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state_q     <= StIdle;
            cmd_ready_q <= 1'b0;
            cmd_err_q   <= 1'b0;
            beat_addr_q <= '0;
            beat_strb_q <= '0;
            beat_num_q  <= '0;
            beat_last_q <= 1'b0;
            len_q       <= '0;
            size_q      <= '0;
            burst_q     <= '0;
            wrap_lo_q   <= '0;
            wrap_hi_q   <= '0;
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= cmd_ready_d;
            cmd_err_q   <= cmd_err_d;
            beat_addr_q <= beat_addr_d;
            beat_strb_q <= beat_strb_d;
            beat_num_q  <= beat_num_d;
            beat_last_q <= beat_last_d;
            len_q       <= len_d;
            size_q      <= size_d;
            burst_q     <= burst_d;
            wrap_lo_q   <= wrap_lo_d;
            wrap_hi_q   <= wrap_hi_d;
        end
    end

    assign cmd_ready  = cmd_ready_q;
    assign cmd_err    = cmd_err_q;
    assign beat_valid = (state_q == StBurst);
    assign beat_addr  = beat_addr_q;
    assign beat_strb  = beat_strb_q;
    assign beat_num   = beat_num_q;
    assign beat_last  = beat_last_q;

endmodule

// File: tb/tb_axi_burst_addr_seq.sv
// Directed bench for axi_burst_addr_seq (32-bit data, 16-bit address); honours AXI_SEQ_4KB_CHECK_EN.
module tb_axi_burst_addr_seq;

    logic        ACLK;
    logic        ARESET;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [15:0] cmd_addr;
    logic [7:0]  cmd_len;
    logic [2:0]  cmd_size;
    logic [1:0]  cmd_burst;
    logic        cmd_err;
    logic        beat_valid;
    logic        beat_ready;
    logic [15:0] beat_addr;
    logic [3:0]  beat_strb;
    logic [7:0]  beat_num;
    logic        beat_last;

    int ntests = 0;
    int nfail  = 0;

    axi_burst_addr_seq #(
        .DATA_WIDTH(32),
        .ADDR_WIDTH(16)
    ) dut (
        .ACLK      (ACLK),
        .ARESET    (ARESET),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_addr  (cmd_addr),
        .cmd_len   (cmd_len),
        .cmd_size  (cmd_size),
        .cmd_burst (cmd_burst),
        .cmd_err   (cmd_err),
        .beat_valid(beat_valid),
        .beat_ready(beat_ready),
        .beat_addr (beat_addr),
        .beat_strb (beat_strb),
        .beat_num  (beat_num),
        .beat_last (beat_last)
    );

    initial begin
        ACLK = 1'b0;
        forever #5 ACLK = ~ACLK;
    end

    // Waits (bounded) for cmd_ready, presents one command for one edge, returns at the next negedge.
    task automatic send_cmd(input logic [15:0] a, input logic [7:0] l, input logic [2:0] s,
                            input logic [1:0] b);
        int n;
        n = 0;
        while (cmd_ready !== 1'b1 && n < 20) begin
            @(negedge ACLK);
            n++;
        end
        ntests++;
        if (cmd_ready !== 1'b1) begin
            nfail++;
            $display("FAIL send_cmd_ready: cmd_ready=%b want 1", cmd_ready);
        end
        cmd_addr  = a;
        cmd_len   = l;
        cmd_size  = s;
        cmd_burst = b;
        cmd_valid = 1'b1;
        @(negedge ACLK);
        cmd_valid = 1'b0;
    endtask

    task automatic test_reset();
        ARESET = 1'b1; cmd_valid = 1'b0; beat_ready = 1'b0;
        cmd_addr = '0; cmd_len = '0; cmd_size = '0; cmd_burst = '0;
        @(negedge ACLK);
        @(negedge ACLK);
        ntests++;
        if ({cmd_ready, cmd_err, beat_valid, beat_last, beat_addr, beat_strb, beat_num} !== 31'd0) begin
            nfail++;
            $display("FAIL reset_outputs: rdy=%b err=%b vld=%b last=%b addr=%h strb=%b num=%0d want all 0",
                     cmd_ready, cmd_err, beat_valid, beat_last, beat_addr, beat_strb, beat_num);
        end
        ARESET = 1'b0;
        #1;
        ntests++;
        if (cmd_ready !== 1'b0) begin
            nfail++;
            $display("FAIL reset_release_ready_early: cmd_ready=%b want 0", cmd_ready);
        end
        @(negedge ACLK);
        ntests++;
        if (cmd_ready !== 1'b1 || beat_valid !== 1'b0) begin
            nfail++;
            $display("FAIL reset_first_cycle: cmd_ready=%b beat_valid=%b want 1 0", cmd_ready, beat_valid);
        end
    endtask

    task automatic test_incr();
        logic [15:0] ea [4] = '{16'h0002, 16'h0004, 16'h0008, 16'h000C};
        logic [3:0]  es [4] = '{4'b1100, 4'b1111, 4'b1111, 4'b1111};
        beat_ready = 1'b1;
        send_cmd(16'h0002, 8'd3, 3'd2, 2'b01);
        for (int i = 0; i < 4; i++) begin
            ntests++;
            if (beat_valid !== 1'b1 || beat_addr !== ea[i] || beat_strb !== es[i] ||
                beat_num !== 8'(i) || beat_last !== (i == 3)) begin
                nfail++;
                $display("FAIL incr_beat%0d: vld=%b addr=%h strb=%b num=%0d last=%b want 1 %h %b %0d %b",
                         i, beat_valid, beat_addr, beat_strb, beat_num, beat_last,
                         ea[i], es[i], i, (i == 3));
            end
            @(negedge ACLK);
        end
        ntests++;
        if (beat_valid !== 1'b0 || cmd_ready !== 1'b0) begin
            nfail++;
            $display("FAIL incr_end: beat_valid=%b cmd_ready=%b want 0 0", beat_valid, cmd_ready);
        end
        @(negedge ACLK);
        ntests++;
        if (cmd_ready !== 1'b1) begin
            nfail++;
            $display("FAIL incr_ready_back: cmd_ready=%b want 1", cmd_ready);
        end
    endtask

    task automatic test_wrap();
        logic [15:0] ea [4] = '{16'h0038, 16'h003C, 16'h0030, 16'h0034};
        beat_ready = 1'b1;
        send_cmd(16'h0038, 8'd3, 3'd2, 2'b10);
        for (int i = 0; i < 4; i++) begin
            ntests++;
            if (beat_valid !== 1'b1 || beat_addr !== ea[i] || beat_strb !== 4'b1111 ||
                beat_num !== 8'(i) || beat_last !== (i == 3)) begin
                nfail++;
                $display("FAIL wrap_beat%0d: vld=%b addr=%h strb=%b num=%0d last=%b want 1 %h 1111 %0d %b",
                         i, beat_valid, beat_addr, beat_strb, beat_num, beat_last, ea[i], i, (i == 3));
            end
            @(negedge ACLK);
        end
        ntests++;
        if (beat_valid !== 1'b0) begin
            nfail++;
            $display("FAIL wrap_end: beat_valid=%b want 0", beat_valid);
        end
    endtask

    task automatic test_fixed_stall();
        logic       rdy [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        logic [7:0] en  [5] = '{8'd0, 8'd1, 8'd1, 8'd2, 8'd2};
        beat_ready = 1'b1;
        send_cmd(16'h0011, 8'd2, 3'd0, 2'b00);
        for (int i = 0; i < 5; i++) begin
            beat_ready = rdy[i];
            ntests++;
            if (beat_valid !== 1'b1 || beat_addr !== 16'h0011 || beat_strb !== 4'b0010 ||
                beat_num !== en[i] || beat_last !== (en[i] == 8'd2)) begin
                nfail++;
                $display("FAIL fixed_cyc%0d: vld=%b addr=%h strb=%b num=%0d last=%b want 1 0011 0010 %0d %b",
                         i, beat_valid, beat_addr, beat_strb, beat_num, beat_last, en[i], (en[i] == 8'd2));
            end
            @(negedge ACLK);
        end
        ntests++;
        if (beat_valid !== 1'b0) begin
            nfail++;
            $display("FAIL fixed_end: beat_valid=%b want 0", beat_valid);
        end
        beat_ready = 1'b1;
    endtask

    task automatic test_back_to_back();
        logic        rdy [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
        logic [15:0] ea  [4] = '{16'h0040, 16'h0040, 16'h0042, 16'h0044};
        logic [3:0]  es  [4] = '{4'b0011, 4'b0011, 4'b1100, 4'b0011};
        logic [7:0]  en  [4] = '{8'd0, 8'd0, 8'd1, 8'd2};
        send_cmd(16'h0040, 8'd2, 3'd1, 2'b01);
        for (int i = 0; i < 4; i++) begin
            beat_ready = rdy[i];
            ntests++;
            if (beat_valid !== 1'b1 || beat_addr !== ea[i] || beat_strb !== es[i] ||
                beat_num !== en[i] || beat_last !== (en[i] == 8'd2)) begin
                nfail++;
                $display("FAIL b2b_cyc%0d: vld=%b addr=%h strb=%b num=%0d last=%b want 1 %h %b %0d %b",
                         i, beat_valid, beat_addr, beat_strb, beat_num, beat_last,
                         ea[i], es[i], en[i], (en[i] == 8'd2));
            end
            @(negedge ACLK);
        end
        beat_ready = 1'b1;
        send_cmd(16'h0080, 8'd0, 3'd2, 2'b01);
        ntests++;
        if (beat_valid !== 1'b1 || beat_addr !== 16'h0080 || beat_last !== 1'b1) begin
            nfail++;
            $display("FAIL b2b_second: vld=%b addr=%h last=%b want 1 0080 1", beat_valid, beat_addr, beat_last);
        end
        @(negedge ACLK);
    endtask

    task automatic test_illegal();
        logic [15:0] ia [4] = '{16'h0000, 16'h0000, 16'h0030, 16'h0032};
        logic [7:0]  il [4] = '{8'd0, 8'd0, 8'd2, 8'd3};
        logic [2:0]  is [4] = '{3'd0, 3'd3, 3'd2, 3'd2};
        logic [1:0]  ib [4] = '{2'b11, 2'b01, 2'b10, 2'b10};
        beat_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            send_cmd(ia[i], il[i], is[i], ib[i]);
            ntests++;
            if (cmd_err !== 1'b1 || beat_valid !== 1'b0) begin
                nfail++;
                $display("FAIL illegal%0d_err: cmd_err=%b beat_valid=%b want 1 0", i, cmd_err, beat_valid);
            end
            @(negedge ACLK);
            ntests++;
            if (cmd_err !== 1'b0 || beat_valid !== 1'b0 || cmd_ready !== 1'b1) begin
                nfail++;
                $display("FAIL illegal%0d_after: cmd_err=%b beat_valid=%b cmd_ready=%b want 0 0 1",
                         i, cmd_err, beat_valid, cmd_ready);
            end
        end
        send_cmd(16'h0100, 8'd0, 3'd1, 2'b01);
        ntests++;
        if (beat_valid !== 1'b1 || beat_addr !== 16'h0100 || beat_strb !== 4'b0011 ||
            beat_num !== 8'd0 || beat_last !== 1'b1 || cmd_err !== 1'b0) begin
            nfail++;
            $display("FAIL illegal_recover: vld=%b addr=%h strb=%b num=%0d last=%b err=%b want 1 0100 0011 0 1 0",
                     beat_valid, beat_addr, beat_strb, beat_num, beat_last, cmd_err);
        end
        @(negedge ACLK);
    endtask

    task automatic test_4kb();
        beat_ready = 1'b1;
        send_cmd(16'h0FF0, 8'd7, 3'd2, 2'b01);
`ifdef AXI_SEQ_4KB_CHECK_EN
        ntests++;
        if (cmd_err !== 1'b1 || beat_valid !== 1'b0) begin
            nfail++;
            $display("FAIL 4kb_err: cmd_err=%b beat_valid=%b want 1 0", cmd_err, beat_valid);
        end
        @(negedge ACLK);
`else
        for (int i = 0; i < 8; i++) begin
            ntests++;
            if (beat_valid !== 1'b1 || beat_addr !== 16'(16'h0FF0 + 4 * i) || beat_strb !== 4'b1111 ||
                beat_last !== (i == 7) || cmd_err !== 1'b0) begin
                nfail++;
                $display("FAIL 4kb_beat%0d: vld=%b addr=%h strb=%b last=%b err=%b want 1 %h 1111 %b 0",
                         i, beat_valid, beat_addr, beat_strb, beat_last, cmd_err,
                         16'(16'h0FF0 + 4 * i), (i == 7));
            end
            @(negedge ACLK);
        end
`endif
        ntests++;
        if (beat_valid !== 1'b0) begin
            nfail++;
            $display("FAIL 4kb_end: beat_valid=%b want 0", beat_valid);
        end
    endtask

    task automatic test_long_incr();
        beat_ready = 1'b1;
        send_cmd(16'h0000, 8'd255, 3'd2, 2'b01);
        for (int i = 0; i < 256; i++) begin
            ntests++;
            if (beat_valid !== 1'b1 || beat_addr !== 16'(4 * i) || beat_num !== 8'(i) ||
                beat_last !== (i == 255)) begin
                nfail++;
                $display("FAIL long_beat%0d: vld=%b addr=%h num=%0d last=%b want 1 %h %0d %b",
                         i, beat_valid, beat_addr, beat_num, beat_last, 16'(4 * i), i, (i == 255));
            end
            @(negedge ACLK);
        end
        ntests++;
        if (beat_valid !== 1'b0) begin
            nfail++;
            $display("FAIL long_end: beat_valid=%b want 0", beat_valid);
        end
    endtask

    task automatic test_reset_mid_burst();
        beat_ready = 1'b1;
        send_cmd(16'h0200, 8'd15, 3'd2, 2'b01);
        repeat (5) @(negedge ACLK);
        ntests++;
        if (beat_valid !== 1'b1 || beat_num !== 8'd5 || beat_addr !== 16'h0214) begin
            nfail++;
            $display("FAIL midrst_beat5: vld=%b num=%0d addr=%h want 1 5 0214", beat_valid, beat_num, beat_addr);
        end
        ARESET = 1'b1;
        #1;
        ntests++;
        if (beat_valid !== 1'b0 || cmd_ready !== 1'b0 || cmd_err !== 1'b0 || beat_num !== 8'd0 ||
            beat_last !== 1'b0) begin
            nfail++;
            $display("FAIL midrst_abort: vld=%b rdy=%b err=%b num=%0d last=%b want 0 0 0 0 0",
                     beat_valid, cmd_ready, cmd_err, beat_num, beat_last);
        end
        @(negedge ACLK);
        ARESET = 1'b0;
        @(negedge ACLK);
        ntests++;
        if (cmd_ready !== 1'b1 || beat_valid !== 1'b0 || cmd_err !== 1'b0) begin
            nfail++;
            $display("FAIL midrst_release: rdy=%b vld=%b err=%b want 1 0 0", cmd_ready, beat_valid, cmd_err);
        end
    endtask

    initial begin
        test_reset();
        test_incr();
        test_wrap();
        test_fixed_stall();
        test_back_to_back();
        test_illegal();
        test_4kb();
        test_long_incr();
        test_reset_mid_burst();
        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
